// File: rtl/modulo_temporizador_pkg.sv
// Shared constants for the BCD countdown timer: FSM encodings, digit limit
// and the default synchroniser depth.
package modulo_temporizador_pkg;

  typedef logic [3:0] bcd_t;

  localparam int SYNC_STAGES_DEF = 2;

  localparam bcd_t BCD_MAX = 4'd9;

  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_RUNNING = 2'b01;
  localparam logic [1:0] ST_PAUSED  = 2'b10;
  localparam logic [1:0] ST_DONE    = 2'b11;

  function automatic bcd_t clamp_bcd(input bcd_t digit);
    bcd_t result;
    if (digit > BCD_MAX) begin
      result = BCD_MAX;
    end else begin
      result = digit;
    end
    return result;
  endfunction

endpackage

// File: rtl/modulo_detector_borda.sv
// Synchronises clock_div into the clock domain and emits a one-cycle tick
// on each synchronised rising edge.
module modulo_detector_borda
  import modulo_temporizador_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic clock,
  input  logic clear,
  input  logic clock_div,
  output logic tick
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   prev_r;
  logic [2:0]             fill_r;
  logic                   armed_s;

  // The edge flop only holds a genuine sample once the chain has refilled
  // after reset, so a level already high at release is not taken as a rise.
  assign armed_s = (fill_r >= 3'(SYNC_STAGES + 1));
  assign tick    = armed_s & sync_r[SYNC_STAGES-1] & ~prev_r;

  // Synchroniser chain, edge flop and post-reset fill counter.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      sync_r <= {SYNC_STAGES{1'b0}};
      prev_r <= 1'b0;
      fill_r <= 3'd0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], clock_div};
      prev_r <= sync_r[SYNC_STAGES-1];
      if (!armed_s) begin
        fill_r <= fill_r + 3'd1;
      end
    end
  end

endmodule

// File: rtl/modulo_temporizador_contagem.sv
// Two-digit BCD countdown timer with load/start/pause control, advanced by
// ticks derived from the external divided clock.
module modulo_temporizador_contagem
  import modulo_temporizador_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic       clock,
  input  logic       clear,
  input  logic       clock_div,
  input  logic       load,
  input  logic [3:0] valor_dezena,
  input  logic [3:0] valor_unidade,
  input  logic       start,
  input  logic       pause,
  output logic [3:0] dezena,
  output logic [3:0] unidade,
  output logic [1:0] estado,
  output logic       ativo,
  output logic       fim
);

  logic       tick_s;
  logic [1:0] estado_r, estado_s;
  bcd_t       dezena_r, dezena_s, unidade_r, unidade_s;
  bcd_t       dec_dez_s, dec_uni_s;
  logic       fim_r, fim_s, ativo_r;
  logic       zero_s, dec_zero_s;

  modulo_detector_borda #(.SYNC_STAGES(SYNC_STAGES)) u_detector (
    .clock     (clock),
    .clear     (clear),
    .clock_div (clock_div),
    .tick      (tick_s)
  );

  assign zero_s     = (dezena_r == 4'd0) && (unidade_r == 4'd0);
  assign dec_zero_s = (dec_dez_s == 4'd0) && (dec_uni_s == 4'd0);

  // BCD decrement with units wrap and tens borrow.
  always_comb begin
    dec_dez_s = dezena_r;
    dec_uni_s = unidade_r;
    if (unidade_r == 4'd0) begin
      dec_uni_s = BCD_MAX;
      dec_dez_s = dezena_r - 4'd1;
    end else begin
      dec_uni_s = unidade_r - 4'd1;
    end
  end

  // Next-state and next-count logic.
  always_comb begin
    estado_s  = estado_r;
    dezena_s  = dezena_r;
    unidade_s = unidade_r;
    fim_s     = 1'b0;
    case (estado_r)
      ST_IDLE: begin
        if (load) begin
          dezena_s  = clamp_bcd(valor_dezena);
          unidade_s = clamp_bcd(valor_unidade);
        end else if (start) begin
          if (zero_s) begin
            estado_s = ST_DONE;
            fim_s    = 1'b1;
          end else begin
            estado_s = ST_RUNNING;
          end
        end else begin
          estado_s = ST_IDLE;
        end
      end
      ST_RUNNING: begin
        // A tick coinciding with pause is applied first; reaching 00 wins.
        if (tick_s) begin
          dezena_s  = dec_dez_s;
          unidade_s = dec_uni_s;
          if (dec_zero_s) begin
            estado_s = ST_DONE;
            fim_s    = 1'b1;
          end else if (pause) begin
            estado_s = ST_PAUSED;
          end else begin
            estado_s = ST_RUNNING;
          end
        end else if (pause) begin
          estado_s = ST_PAUSED;
        end else begin
          estado_s = ST_RUNNING;
        end
      end
      ST_PAUSED: begin
        if (load) begin
          dezena_s  = clamp_bcd(valor_dezena);
          unidade_s = clamp_bcd(valor_unidade);
          estado_s  = ST_IDLE;
        end else if (start) begin
          estado_s = ST_RUNNING;
        end else begin
          estado_s = ST_PAUSED;
        end
      end
      ST_DONE: begin
        if (load) begin
          dezena_s  = clamp_bcd(valor_dezena);
          unidade_s = clamp_bcd(valor_unidade);
          estado_s  = ST_IDLE;
        end else begin
          estado_s = ST_DONE;
        end
      end
      default: begin
        estado_s  = ST_IDLE;
        dezena_s  = 4'd0;
        unidade_s = 4'd0;
      end
    endcase
  end

  // State, count and registered status outputs.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      estado_r  <= ST_IDLE;
      dezena_r  <= 4'd0;
      unidade_r <= 4'd0;
      fim_r     <= 1'b0;
      ativo_r   <= 1'b0;
    end else begin
      estado_r  <= estado_s;
      dezena_r  <= dezena_s;
      unidade_r <= unidade_s;
      fim_r     <= fim_s;
      ativo_r   <= (estado_s == ST_RUNNING);
    end
  end

  assign dezena  = dezena_r;
  assign unidade = unidade_r;
  assign estado  = estado_r;
  assign ativo   = ativo_r;
  assign fim     = fim_r;

endmodule

// File: tb/tb_modulo_temporizador_contagem.sv
// Scoreboard bench for the BCD countdown timer: an integer-count reference
// model queues expected outputs, a negedge monitor pops and compares them.
module tb_modulo_temporizador_contagem;

  localparam int S = 2;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_DONE = 3;

  typedef struct packed {
    logic [3:0] d;
    logic [3:0] u;
    logic [1:0] e;
    logic       a;
    logic       f;
  } exp_t;

  logic       clock = 1'b0;
  logic       clear = 1'b0;
  logic       clock_div = 1'b0;
  logic       load = 1'b0;
  logic [3:0] valor_dezena = 4'd0;
  logic [3:0] valor_unidade = 4'd0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic [3:0] dezena, unidade;
  logic [1:0] estado;
  logic       ativo, fim;

  int   vectors = 0;
  int   miscompares = 0;
  exp_t exp_q[$];
  bit   m_hist[$];
  int   m_cnt = 0;
  int   m_st = M_IDLE;
  logic fim_prev = 1'b0;

  modulo_temporizador_contagem #(.SYNC_STAGES(S)) dut (
    .clock         (clock),
    .clear         (clear),
    .clock_div     (clock_div),
    .load          (load),
    .valor_dezena  (valor_dezena),
    .valor_unidade (valor_unidade),
    .start         (start),
    .pause         (pause),
    .dezena        (dezena),
    .unidade       (unidade),
    .estado        (estado),
    .ativo         (ativo),
    .fim           (fim)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish within the time limit");
    $fatal(1, "timeout");
  end

  // Reference model for one clock edge, using the inputs currently driven.
  task automatic model_edge();
    int   k, pre, vd, vu;
    bit   tick;
    logic f;
    exp_t e;
    m_hist.push_back(clock_div);
    k = m_hist.size();
    // A rise is seen S edges after it is sampled, once a real prior sample exists.
    tick = (k >= S + 2) && m_hist[k-1-S] && !m_hist[k-2-S];
    vd = (int'(valor_dezena) > 9) ? 9 : int'(valor_dezena);
    vu = (int'(valor_unidade) > 9) ? 9 : int'(valor_unidade);
    pre = vd * 10 + vu;
    f = 1'b0;
    if (m_st == M_IDLE) begin
      if (load) m_cnt = pre;
      else if (start) begin
        if (m_cnt == 0) begin m_st = M_DONE; f = 1'b1; end
        else m_st = M_RUN;
      end
    end else if (m_st == M_RUN) begin
      if (tick) m_cnt = m_cnt - 1;
      if (tick && m_cnt == 0) begin m_st = M_DONE; f = 1'b1; end
      else if (pause) m_st = M_PAUSED;
    end else if (m_st == M_PAUSED) begin
      if (load) begin m_cnt = pre; m_st = M_IDLE; end
      else if (start) m_st = M_RUN;
    end else begin
      if (load) begin m_cnt = pre; m_st = M_IDLE; end
    end
    e.d = 4'(m_cnt / 10);
    e.u = 4'(m_cnt % 10);
    e.e = 2'(m_st);
    e.a = (m_st == M_RUN);
    e.f = f;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic ld, input logic [3:0] vd, input logic [3:0] vu,
                      input logic st, input logic pa, input logic cd);
    @(negedge clock);
    #1;
    load = ld; valor_dezena = vd; valor_unidade = vu;
    start = st; pause = pa; clock_div = cd;
    @(posedge clock);
    model_edge();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, clock_div);
  endtask

  task automatic div_edges(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    end
  endtask

  task automatic do_reset(input logic cd_hold);
    @(negedge clock);
    #2;
    clear = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0; clock_div = cd_hold;
    #1;
    vectors++;
    if ({dezena, unidade, estado, ativo, fim} !== 13'd0) begin
      miscompares++;
      $display("FAIL reset_async: got d=%0d u=%0d estado=%b ativo=%b fim=%b, want all zero",
               dezena, unidade, estado, ativo, fim);
    end
    m_cnt = 0;
    m_st = M_IDLE;
    m_hist.delete();
    @(posedge clock);
    #2;
    clear = 1'b1;
  endtask

  // Monitor: compare every cycle's outputs against the queued expectation.
  always @(negedge clock) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if ({dezena, unidade, estado, ativo, fim} !== e) begin
        miscompares++;
        $display("FAIL outputs @%0t: got d=%0d u=%0d estado=%b ativo=%b fim=%b, want d=%0d u=%0d estado=%b ativo=%b fim=%b",
                 $time, dezena, unidade, estado, ativo, fim, e.d, e.u, e.e, e.a, e.f);
      end
      if (fim === 1'b1 && fim_prev === 1'b1) begin
        miscompares++;
        $display("FAIL fim_width @%0t: got fim high two cycles in a row, want single-cycle pulse", $time);
      end
      fim_prev = fim;
    end
  end

  initial begin
    do_reset(1'b0);
    idle(4);

    // Load 25, start, three divided-clock rises -> 22 running.
    step(1'b1, 4'd2, 4'd5, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    div_edges(3);
    idle(3);

    // Pause, load 10, start, one rise -> 09.
    step(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 4'd1, 4'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    div_edges(1);
    idle(3);

    // Load 02, two rises -> DONE with fim; a third rise changes nothing.
    step(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 4'd0, 4'd2, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    div_edges(2);
    idle(3);
    div_edges(1);
    idle(3);

    // Load 50, one rise, pause through four rises, resume, one rise -> 48.
    step(1'b1, 4'd5, 4'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    div_edges(1);
    idle(3);
    step(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0);
    div_edges(4);
    idle(3);
    step(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    div_edges(1);
    idle(3);

    // Clamp 12/15 to 99, then load 00 and start -> immediate DONE.
    step(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 4'd12, 4'd15, 1'b0, 1'b0, 1'b0);
    idle(2);
    step(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    idle(3);

    // Running at 37, reset mid-cycle with clock_div held high across release.
    step(1'b1, 4'd3, 4'd7, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    idle(2);
    do_reset(1'b1);
    step(1'b1, 4'd0, 4'd5, 1'b0, 1'b0, 1'b1);
    step(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b1);
    idle(6);

    // Randomised traffic, including occasional resets.
    for (int i = 0; i < 600; i++) begin
      logic cd;
      cd = clock_div;
      if ($urandom_range(0, 3) == 0) cd = ~cd;
      if ($urandom_range(0, 249) == 0) begin
        do_reset(cd);
      end else begin
        step(($urandom_range(0, 7) == 0),
             4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
             ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0), cd);
      end
    end
    idle(2);

    @(negedge clock);
    #2;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/modulo_temporizador_contagem.md
MODULO_TEMPORIZADOR_CONTAGEM -- requirements
Module: modulo_temporizador_contagem

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of synchroniser flops on clock_div (legal 2..3).
REQ-002 Port clock  input  1  system clock; all state changes on its rising edge; the design has one clock only.
REQ-003 Port clear  input  1  reset, asynchronous, active-low.
REQ-004 Port clock_div  input  1  divided clock from the frequency divider; sampled as data, never used as a clock.
REQ-005 Port load  input  1  load request for the preset value.
REQ-006 Port valor_dezena  input  4  BCD tens digit of the preset value.
REQ-007 Port valor_unidade  input  4  BCD units digit of the preset value.
REQ-008 Port start  input  1  start or resume the countdown.
REQ-009 Port pause  input  1  pause the countdown.
REQ-010 Port dezena  output  4  current BCD tens digit.
REQ-011 Port unidade  output  4  current BCD units digit.
REQ-012 Port estado  output  2  FSM state: IDLE=00, RUNNING=01, PAUSED=10, DONE=11.
REQ-013 Port ativo  output  1  high exactly while estado=RUNNING.
REQ-014 Port fim  output  1  one-cycle pulse when the count reaches 00.

Function
REQ-015 clock_div shall pass through SYNC_STAGES flops; the internal tick pulses for one clock cycle when the synchronised value rises.
REQ-016 The tick shall be high during the cycle after the SYNC_STAGES-th clock edge following a setup-meeting clock_div rise; falling edges generate no tick.
REQ-017 The count shall be a 2-digit BCD value 00..99; each loaded digit >9 shall be clamped to 9.
REQ-018 IDLE: load latches the preset and stays in IDLE; otherwise start goes to RUNNING if count≠00, or to DONE with a fim pulse if count=00; load beats start in the same cycle.
REQ-019 RUNNING: each tick decrements by 1; unidade 0 -> 9 with dezena-1; load is ignored.
REQ-020 RUNNING: a tick that makes the count 00 moves to DONE on the same edge, and fim is high for the following single cycle.
REQ-021 RUNNING: pause moves to PAUSED; if a tick coincides with pause, the decrement is applied first; if that decrement reaches 00, DONE wins over PAUSED.
REQ-022 PAUSED: the count is held and ticks are ignored; start returns to RUNNING; load latches the preset and goes to IDLE; load beats start.
REQ-023 DONE: the count is held at 00; start is ignored; load latches the preset and goes to IDLE.
REQ-024 The start and pause inputs shall be level-sampled each cycle, with no internal edge detection; pause without start is a no-op in IDLE, PAUSED and DONE.
REQ-025 fim shall never be high for two consecutive cycles.

Reset
REQ-026 While clear=0: estado=IDLE, dezena=0, unidade=0, ativo=0, fim=0, synchroniser and edge flops cleared, all asynchronously.
REQ-027 Reset asserted mid-count shall discard the count; after release, no tick until a fresh clock_div rising edge is synchronised.

Structure
REQ-028 Shared package modulo_temporizador_pkg shall hold the state encodings, BCD_MAX=9 and the SYNC_STAGES default.
REQ-029 Sub-module modulo_detector_borda (synchroniser plus rising-edge detect, outputs tick) shall be instantiated once; the FSM and BCD counter stay in the top level.

Verification
REQ-030 Reset, then load 25, start, apply 3 clock_div rising edges -> count 22, estado=01, ativo=1.
REQ-031 Load 10, start, apply 1 rising edge -> count 09 (units wrap and tens borrow).
REQ-032 Load 02, start, apply 2 edges -> count 00, estado=11, fim high exactly 1 cycle; a 3rd edge leaves the count at 00 with no fim.
REQ-033 Load 50, start, 1 edge (49), pause, 4 edges -> count stays 49, estado=10; start, 1 edge -> 48.
REQ-034 Load with valor_dezena=12 and valor_unidade=15 -> count 99; load 00 then start -> DONE with a 1-cycle fim and no ticks needed.
REQ-035 While RUNNING at 37, pull clear low mid-cycle -> outputs 00, IDLE immediately; clock_div held high across release -> no tick and count stays 00.
